// File: rtl/stopwatch_ctrl_if.sv
// ============================================================================
// Module      : stopwatch_ctrl_if
// Description : Button levels in, counter/display control out, for the
//               stopwatch control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stopwatch_ctrl_if;
  logic [4:0] btn_db;
  logic       count_en;
  logic       count_clr;
  logic       disp_freeze;
  logic       lap_pulse;
  logic       mode_sel;
  logic       locked;
  logic [1:0] state;

  // Master drives the debounced buttons; slave is the control FSM.
  modport master (
    output btn_db,
    input  count_en, count_clr, disp_freeze, lap_pulse, mode_sel, locked, state
  );

  modport slave (
    input  btn_db,
    output count_en, count_clr, disp_freeze, lap_pulse, mode_sel, locked, state
  );
endinterface

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Stopwatch control FSM: button edge detect, priority
//               arbitration, run/pause/lap/clear, mode toggle and panel lock.
//               Optional long-press clear: STOPWATCH_LONGPRESS_CLR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_ctrl #(
  parameter int LONG_CYCLES = 100000000,
  parameter int LP_W        = 27
) (
  input  logic           clk,
  input  logic           rst_n,
  stopwatch_ctrl_if.slave sw
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [4:0] r_btn_q;
  logic [4:0] w_rise;
  logic [4:0] w_ev;
  logic       r_count_clr, r_lap_pulse, r_mode_sel, r_locked;
  logic       w_count_clr_nxt, w_lap_pulse_nxt, w_mode_sel_nxt, w_locked_nxt;
  logic       w_lp_fire;

  assign w_rise = sw.btn_db & ~r_btn_q;

  // One-hot winner: lock > clear > start_stop > lap > mode.
  always_comb begin
    w_ev = '0;
    if      (w_rise[4]) w_ev[4] = 1'b1;
    else if (w_rise[2]) w_ev[2] = 1'b1;
    else if (w_rise[0]) w_ev[0] = 1'b1;
    else if (w_rise[1]) w_ev[1] = 1'b1;
    else if (w_rise[3]) w_ev[3] = 1'b1;
  end

`ifdef STOPWATCH_LONGPRESS_CLR_EN
  localparam logic [LP_W-1:0] c_lp_sat  = LP_W'(LONG_CYCLES);
  localparam logic [LP_W-1:0] c_lp_last = LP_W'(LONG_CYCLES - 1);

  logic [LP_W-1:0] r_lp_cnt;

  // Saturates at LONG_CYCLES so a single hold clears only once, even if the
  // threshold was crossed while locked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_lp_cnt <= '0;
    else if (!sw.btn_db[2])    r_lp_cnt <= '0;
    else if (r_lp_cnt != c_lp_sat) r_lp_cnt <= r_lp_cnt + 1'b1;
  end

  assign w_lp_fire = sw.btn_db[2] & (r_lp_cnt == c_lp_last) & ~r_locked;
`else
  assign w_lp_fire = 1'b0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_count_clr_nxt = 1'b0;
    w_lap_pulse_nxt = 1'b0;
    w_mode_sel_nxt  = r_mode_sel;
    w_locked_nxt    = r_locked;
    if (w_ev[4]) begin
      w_locked_nxt = ~r_locked;
    end else if (w_lp_fire) begin
      w_count_clr_nxt = 1'b1;
      w_state_nxt     = IDLE;
    end else if (!r_locked) begin
      if (w_ev[3]) w_mode_sel_nxt = ~r_mode_sel;
      case (r_state)
        IDLE: begin
          if      (w_ev[0]) w_state_nxt     = RUN;
          else if (w_ev[2]) w_count_clr_nxt = 1'b1;
        end
        RUN: begin
          if (w_ev[0]) begin
            w_state_nxt = PAUSE;
          end else if (w_ev[1]) begin
            w_state_nxt     = LAP;
            w_lap_pulse_nxt = 1'b1;
          end
        end
        LAP: begin
          if      (w_ev[1]) w_state_nxt = RUN;
          else if (w_ev[0]) w_state_nxt = PAUSE;
        end
        PAUSE: begin
          if (w_ev[0]) begin
            w_state_nxt = RUN;
          end else if (w_ev[2]) begin
            w_count_clr_nxt = 1'b1;
            w_state_nxt     = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // All-ones previous level: buttons held across reset release are not events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_btn_q     <= 5'b11111;
      r_count_clr <= 1'b0;
      r_lap_pulse <= 1'b0;
      r_mode_sel  <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_btn_q     <= sw.btn_db;
      r_count_clr <= w_count_clr_nxt;
      r_lap_pulse <= w_lap_pulse_nxt;
      r_mode_sel  <= w_mode_sel_nxt;
      r_locked    <= w_locked_nxt;
    end
  end

  assign sw.state       = r_state;
  assign sw.count_en    = (r_state == RUN) | (r_state == LAP);
  assign sw.disp_freeze = (r_state == LAP);
  assign sw.count_clr   = r_count_clr;
  assign sw.lap_pulse   = r_lap_pulse;
  assign sw.mode_sel    = r_mode_sel;
  assign sw.locked      = r_locked;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
// ============================================================================
// Module      : tb_stopwatch_ctrl
// Description : Scoreboard bench for stopwatch_ctrl: directed plan followed by
//               random button activity against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_ctrl;

  localparam int c_long = 8;
`ifdef STOPWATCH_LONGPRESS_CLR_EN
  localparam bit c_lp_en = 1'b1;
`else
  localparam bit c_lp_en = 1'b0;
`endif

  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_LAP = 3;

  typedef struct packed {
    logic [1:0] st;
    logic       en;
    logic       clr;
    logic       frz;
    logic       lap;
    logic       mode;
    logic       lk;
  } out_t;

  logic clk;
  logic rst_n;
  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(.LONG_CYCLES(c_long), .LP_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sw   (sw_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   step  = 0;
  out_t exp_q[$];

  // Behavioural model state
  int         m_st;
  bit         m_mode, m_lock;
  logic [4:0] m_prev;
  int         m_hold;

  function automatic out_t actual();
    out_t a;
    a.st   = sw_if.state;
    a.en   = sw_if.count_en;
    a.clr  = sw_if.count_clr;
    a.frz  = sw_if.disp_freeze;
    a.lap  = sw_if.lap_pulse;
    a.mode = sw_if.mode_sel;
    a.lk   = sw_if.locked;
    return a;
  endfunction

  task automatic model_step(input logic [4:0] b);
    logic [4:0] rise;
    int         prio[5] = '{4, 2, 0, 1, 3};
    int         ev;
    bit         fire, clr, lap;
    out_t       e;
    rise   = b & ~m_prev;
    m_prev = b;
    m_hold = b[2] ? m_hold + 1 : 0;
    fire   = c_lp_en && (m_hold == c_long) && !m_lock;
    ev = -1;
    for (int k = 0; k < 5; k++)
      if (ev < 0 && rise[prio[k]]) ev = prio[k];
    clr = 0;
    lap = 0;
    if (ev == 4) m_lock = !m_lock;
    else if (fire) begin
      clr  = 1;
      m_st = S_IDLE;
    end else if (!m_lock && ev >= 0) begin
      if (ev == 3) m_mode = !m_mode;
      else if (m_st == S_IDLE && ev == 0) m_st = S_RUN;
      else if (m_st == S_IDLE && ev == 2) clr = 1;
      else if (m_st == S_RUN && ev == 0) m_st = S_PAUSE;
      else if (m_st == S_RUN && ev == 1) begin m_st = S_LAP; lap = 1; end
      else if (m_st == S_LAP && ev == 1) m_st = S_RUN;
      else if (m_st == S_LAP && ev == 0) m_st = S_PAUSE;
      else if (m_st == S_PAUSE && ev == 0) m_st = S_RUN;
      else if (m_st == S_PAUSE && ev == 2) begin m_st = S_IDLE; clr = 1; end
    end
    e.st   = 2'(m_st);
    e.en   = (m_st == S_RUN) || (m_st == S_LAP);
    e.clr  = clr;
    e.frz  = (m_st == S_LAP);
    e.lap  = lap;
    e.mode = m_mode;
    e.lk   = m_lock;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic tick(input logic [4:0] b);
    sw_if.btn_db = b;
    model_step(b);
    @(negedge clk);
  endtask

  task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: outputs are valid every cycle after reset release.
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      out_t e, a;
      e = exp_q.pop_front();
      a = actual();
      step++;
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL outputs step %0d: got st=%b en=%b clr=%b frz=%b lap=%b mode=%b lk=%b expected st=%b en=%b clr=%b frz=%b lap=%b mode=%b lk=%b",
                 step, a.st, a.en, a.clr, a.frz, a.lap, a.mode, a.lk,
                 e.st, e.en, e.clr, e.frz, e.lap, e.mode, e.lk);
      end
    end
  end

  task automatic drain();
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    check_val("queue_drained", 8'(exp_q.size()), 8'd0);
  endtask

  logic [4:0] plan[] = '{
    5'h01, 5'h01, 5'h01, 5'h00, 5'h01, 5'h00, 5'h02, 5'h00, 5'h02, 5'h00,
    5'h01, 5'h00, 5'h04, 5'h00, 5'h00, 5'h01, 5'h00, 5'h01, 5'h00, 5'h05,
    5'h00, 5'h00, 5'h10, 5'h00, 5'h01, 5'h00, 5'h04, 5'h00, 5'h08, 5'h00,
    5'h10, 5'h00, 5'h08, 5'h00
  };

  initial begin
    logic [4:0] b;
    rst_n        = 1'b0;
    sw_if.btn_db = 5'b00001;
    m_st   = S_IDLE;
    m_mode = 0;
    m_lock = 0;
    m_prev = 5'b11111;
    m_hold = 0;
    repeat (3) @(negedge clk);
    check_val("reset_outputs", {1'b0, actual()}, 8'h00);

    rst_n = 1'b1;
    foreach (plan[i]) tick(plan[i]);
    drain();
    check_val("plan_state", 8'(sw_if.state), 8'd0);
    check_val("plan_mode", 8'(sw_if.mode_sel), 8'd1);
    check_val("plan_locked", 8'(sw_if.locked), 8'd0);
    check_val("plan_count_en", 8'(sw_if.count_en), 8'd0);

`ifdef STOPWATCH_LONGPRESS_CLR_EN
    tick(5'h01); tick(5'h00);
    repeat (20) tick(5'h04);
    tick(5'h00);
    drain();
    check_val("long_hold_state", 8'(sw_if.state), 8'd0);
    tick(5'h01); tick(5'h00);
    repeat (7) tick(5'h04);
    tick(5'h00);
    drain();
    check_val("short_hold_state", 8'(sw_if.state), 8'd1);
`endif

    b = 5'h00;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 5; i++)
        if ($urandom_range(5) == 0) b[i] = ~b[i];
      tick(b);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control FSM for the stopwatch. It consumes the 5 debounced button levels from the debounce wrapper and turns them into one-cycle button events.
- It arbitrates simultaneous presses and sequences the time counter and display: run, pause, lap freeze, clear, mode select and a panel lock.
- It sits between the debounce wrapper and the time-counter/display blocks.

Parameters:
- LONG_CYCLES, 100000000, consecutive high cycles on the clear button that count as a long press (2 s at 50 MHz); used only with the optional feature.
- LP_W, 27, width of the long-press counter; must satisfy 2**LP_W > LONG_CYCLES.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- btn_db  input  5  debounced button levels, active high: [0] start_stop, [1] lap, [2] clear, [3] mode, [4] lock.
- count_en  output  1  time counter increments while high.
- count_clr  output  1  one-cycle pulse: zero the time counter.
- disp_freeze  output  1  display holds its latched lap value while high.
- lap_pulse  output  1  one-cycle pulse: latch the current time into the lap register.
- mode_sel  output  1  display mode, toggled by the mode button.
- locked  output  1  panel lock active.
- state  output  2  FSM state: IDLE=00, RUN=01, PAUSE=10, LAP=11.

Behaviour:
- One clock domain (clk); asynchronous active-low reset (rst_n). All flops reset asynchronously.
- Reset values:
  - state=IDLE; count_clr, lap_pulse, mode_sel and locked = 0.
  - btn_q (previous-level register) = 5'b11111, so buttons held through reset release never generate events.
- Edge detect: rise[i] = btn_db[i] & ~btn_q[i]; btn_q <= btn_db every cycle. Only rising edges are events; falling edges and held levels are ignored.
- Latency: an event sampled at edge N updates state and the pulses at edge N+1 (registered outputs).
- Arbitration: when several rises occur in the same cycle, only the highest-priority one is accepted. Priority: lock > clear > start_stop > lap > mode. The others are dropped, not queued.
- Lock:
  - A lock rise toggles locked, in any state.
  - While locked=1, all other events are ignored. The FSM and its outputs hold, and a running counter keeps running.
- Mode: a mode rise (not locked, not outranked) toggles mode_sel in any state. No state change.
- State transitions (accepted event only; anything not listed is ignored, state unchanged):
  - IDLE: start_stop -> RUN. clear -> count_clr pulse, stay IDLE.
  - RUN: start_stop -> PAUSE. lap -> LAP, with lap_pulse.
  - LAP: lap -> RUN (freeze released, no lap_pulse). start_stop -> PAUSE.
  - PAUSE: start_stop -> RUN. clear -> count_clr pulse, then -> IDLE.
- Decoded outputs: count_en = (state==RUN) | (state==LAP); disp_freeze = (state==LAP). Both come from the state register with no extra delay.
- Pulses: count_clr and lap_pulse are exactly 1 cycle wide and never asserted in consecutive cycles from a single press.
- Clear is ignored in RUN and LAP unless the optional feature is enabled.

Optional Feature:
- Macro: STOPWATCH_LONGPRESS_CLR_EN.
- Defined:
  - An LP_W-bit counter counts while btn_db[2] is high. It resets to 0 when btn_db[2] is low, and the rising cycle counts as 1.
  - When the count reaches LONG_CYCLES and locked=0, the block issues a count_clr pulse and forces state to IDLE from any state.
  - The counter then saturates, so there is one clear per hold.
  - A normal short-press clear in IDLE/PAUSE still acts on the rising edge.
  - The long press is suppressed while locked; it does not fire later on unlock while still held.
- Not defined: the counter logic is absent, and clear in RUN/LAP is ignored.

Test Plan:
- Reset with btn_db=5'b00001 held, then release rst_n -> no event; state=00, count_en=0 until btn[0] falls and rises again.
- IDLE, pulse btn[0] -> state=01 and count_en=1 one cycle after the sampled rise. Pulse btn[1] -> state=11, lap_pulse high for 1 cycle, disp_freeze=1. Pulse btn[1] -> state=01, disp_freeze=0.
- RUN, pulse btn[0] -> state=10, count_en=0. Pulse btn[2] -> count_clr high for exactly 1 cycle, state=00.
- Simultaneous rise btn_db=5'b00101 in PAUSE -> clear wins: count_clr=1, state=00. Start ignored, state stays 00 next cycle.
- Pulse btn[4] -> locked=1. Pulses on btn[0], btn[2], btn[3] -> no change to state, mode_sel or pulses. Pulse btn[4] -> locked=0. Pulse btn[3] -> mode_sel toggles 0->1.
- With STOPWATCH_LONGPRESS_CLR_EN and LONG_CYCLES=8: in RUN, hold btn[2] for 20 cycles -> exactly one count_clr pulse, at the 8th high cycle, then state=00. Hold for 7 cycles -> no clear, state=01.
